mig_ui_responder: RTL
=====================

// Module: mig_ui_responder
// PURPOSE
//  Cycle-accurate responder for the Xilinx MIG 7-series user interface (app_* ports): the memory-side end of apb_mig traffic.
//  Accepts write/read commands plus the write-data stream, stores words in a small internal array, and returns read data in order after a fixed latency.
//  Drives the apb-to-mig bridge in block and system benches; synthesizable so it can stand in for DDR on FPGA smoke builds.
// PARAMETERS
//  ADDR_WIDTH   27   app_addr width (= apb_mig_pkg::MIG_ADDR_WIDTH)
//  DATA_WIDTH   128  app data width (= apb_mig_pkg::DATA_WIDTH)
//  MEM_DEPTH    64   words in internal array, power of 2
//  RD_LATENCY   4    cycles from read-cmd acceptance to app_rd_data_valid_o, >=1
//  WDF_DEPTH    4    write-data FIFO entries, power of 2
//  CALIB_CYCLES 16   cycles after reset release before init_calib_complete_o
// PORTS
//  clk_i                 in   1           clock
//  rst_ni                in   1           synchronous reset, active-low
//  init_calib_complete_o out  1           calibration done
//  app_addr_i            in   ADDR_WIDTH  command address
//  app_cmd_i             in   3           3'b000 write, 3'b001 read, others illegal
//  app_en_i              in   1           command valid
//  app_rdy_o             out  1           command ready
//  app_wdf_data_i        in   DATA_WIDTH  write data
//  app_wdf_mask_i        in   DATA_WIDTH/8  byte mask, 1 = byte NOT written
//  app_wdf_wren_i        in   1           write data valid
//  app_wdf_end_i         in   1           last beat (must equal wren; single-beat BL8)
//  app_wdf_rdy_o         out  1           write FIFO ready
//  app_rd_data_o         out  DATA_WIDTH  read data
//  app_rd_data_valid_o   out  1           read data valid, no backpressure
//  app_rd_data_end_o     out  1           = app_rd_data_valid_o
//  err_o                 out  1           sticky protocol error
// BEHAVIOUR
//  Reset (rst_ni=0 at posedge): all outputs 0; calib counter, WDF, read pipeline, err cleared. Memory array NOT cleared.
//  Calib: counter runs from reset release; init_calib_complete_o=1 at cycle CALIB_CYCLES, then stays 1. Before that app_rdy_o=app_wdf_rdy_o=0.
//  Handshakes: cmd accepted when app_en_i & app_rdy_o; data pushed when app_wdf_wren_i & app_wdf_rdy_o. Master holds inputs until accepted.
//  app_wdf_rdy_o = calib & !wdf_full. Data may precede its command by any number of beats up to WDF_DEPTH.
//  app_rdy_o = calib & !(app_cmd_i==WRITE & wdf_empty); write cmd with no queued data stalls until a beat is in the FIFO (push-to-pop 1 cycle).
//  Index = app_addr_i[$clog2(MEM_DEPTH)+2:3]; addr[2:0]!=0 sets err_o, access still done; upper bits ignored (wrap modulo MEM_DEPTH).
//  Write accept: pop WDF head, write unmasked bytes to mem[index] same edge.
//  Read accept: mem[index] sampled same edge (includes a write committed that edge? no: a write accepted earlier edge is visible; cmds are one per cycle, so RAW always sees new data).
//  Read pipeline: RD_LATENCY-stage shift register; data valid exactly RD_LATENCY cycles after accept edge; strictly in order; back-to-back reads -> back-to-back valid.
//  Illegal cmd: accepted, no access, err_o set. app_wdf_end_i!=app_wdf_wren_i: err_o set.
//  Simultaneous WDF push+pop: allowed, count unchanged; when full, push+pop in same cycle not possible since wdf_rdy is 0 (no combinational dependence on pop).
//  Reset mid-operation: in-flight reads dropped (no valid), queued write data discarded, calib restarts.
// CONFIGURATION
//  MIG_RESP_BACKPRESSURE_EN defined: 8-bit LFSR (seed 8'hA5 at reset) masks app_rdy_o and app_wdf_rdy_o independently with a 25% stall probability after calib.
//  Undefined: ready depends only on the rules above; no LFSR logic.
// STRUCTURE
//  apb_mig_pkg gains: mig_cmd_e (MIG_CMD_WRITE=3'b000, MIG_CMD_READ=3'b001), corrected strb_t [STRB_WIDTH-1:0], data_t [STRB_WIDTH-1:0][7:0].
//  Sub-module mig_wdf_fifo: sync FIFO {data,mask}, params WIDTH/DEPTH, ports push/pop/full/empty; rest flat in top.
// TESTING
//  Reset then idle -> init_calib_complete_o rises exactly 16 cycles after rst_ni=1; rdy signals 0 before.
//  Write addr 0x08 data 128'h0123..EF mask 0, then read 0x08 -> valid at accept+4 with same data, end=1.
//  Write addr 0x10 mask 16'hFFF0 data all 8'hFF over prior zeros -> read returns 128'h0000..0000_FFFF_FFFF.
//  Write cmd before data -> app_rdy_o=0 until wren; 5 data beats before any cmd -> wdf_rdy_o=0 on 5th.
//  8 back-to-back reads addrs 0x00..0x38 -> 8 consecutive valid cycles in order; addr 0x200 aliases 0x00.
//  cmd=3'b010 or addr 0x04 -> err_o=1 and stays 1 until reset; with MIG_RESP_BACKPRESSURE_EN random stalls, data still correct.

Source files
------------

// File: rtl/mig_ui_responder_pkg.sv
// Shared types and helpers for the MIG UI responder.
// MIG_RESP_BACKPRESSURE_EN enables the LFSR stall generator in the top.
package mig_ui_responder_pkg;

  localparam int MIG_ADDR_WIDTH = 27;
  localparam int DATA_WIDTH     = 128;
  localparam int STRB_WIDTH     = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    MIG_CMD_WRITE = 3'b000,
    MIG_CMD_READ  = 3'b001
  } mig_cmd_e;

  typedef logic [STRB_WIDTH-1:0]      strb_t;
  typedef logic [STRB_WIDTH-1:0][7:0] data_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/mig_ui_responder_if.sv
// MIG 7-series app_* user interface bundle; master = controller user, slave = memory side.
interface mig_ui_responder_if #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 128
);
  logic                    init_calib_complete_o;
  logic [ADDR_WIDTH-1:0]   app_addr_i;
  logic [2:0]              app_cmd_i;
  logic                    app_en_i;
  logic                    app_rdy_o;
  logic [DATA_WIDTH-1:0]   app_wdf_data_i;
  logic [DATA_WIDTH/8-1:0] app_wdf_mask_i;
  logic                    app_wdf_wren_i;
  logic                    app_wdf_end_i;
  logic                    app_wdf_rdy_o;
  logic [DATA_WIDTH-1:0]   app_rd_data_o;
  logic                    app_rd_data_valid_o;
  logic                    app_rd_data_end_o;
  logic                    err_o;

  modport master (
    output app_addr_i, app_cmd_i, app_en_i,
    output app_wdf_data_i, app_wdf_mask_i, app_wdf_wren_i, app_wdf_end_i,
    input  init_calib_complete_o, app_rdy_o, app_wdf_rdy_o,
    input  app_rd_data_o, app_rd_data_valid_o, app_rd_data_end_o, err_o
  );

  modport slave (
    input  app_addr_i, app_cmd_i, app_en_i,
    input  app_wdf_data_i, app_wdf_mask_i, app_wdf_wren_i, app_wdf_end_i,
    output init_calib_complete_o, app_rdy_o, app_wdf_rdy_o,
    output app_rd_data_o, app_rd_data_valid_o, app_rd_data_end_o, err_o
  );
endinterface

// File: rtl/mig_ui_responder_wdf_fifo.sv
// Write-data FIFO (mig_wdf_fifo): holds {mask, data} beats that may arrive ahead of their write command.
module mig_wdf_fifo #(
  parameter int WIDTH = 144,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  // NOTE: payload storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push) store[wr_ptr] <= wdata;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = store[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
endmodule

// File: rtl/mig_ui_responder.sv
// Memory-side responder for the MIG 7-series app_* interface with fixed read latency.
// Optional MIG_RESP_BACKPRESSURE_EN adds LFSR-driven random ready stalls.
module mig_ui_responder
  import mig_ui_responder_pkg::*;
#(
  parameter int ADDR_WIDTH   = 27,
  parameter int DATA_WIDTH   = 128,
  parameter int MEM_DEPTH    = 64,
  parameter int RD_LATENCY   = 4,
  parameter int WDF_DEPTH    = 4,
  parameter int CALIB_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  mig_ui_responder_if.slave     app
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W      = $clog2(MEM_DEPTH);
  localparam int CAL_W      = $clog2(CALIB_CYCLES + 1);

  typedef logic [STRB_WIDTH-1:0][7:0] word_t;

  word_t                 mem     [MEM_DEPTH];
  word_t                 rd_pipe [RD_LATENCY];
  logic [RD_LATENCY-1:0] rd_vld;
  logic [CAL_W-1:0]      calib_cnt;
  logic                  calib_q, err_q, rd_valid_q;
  word_t                 rd_data_q;

  logic                  cmd_stall, wdf_stall;
  logic                  wdf_full, wdf_empty, wdf_rdy, cmd_rdy;
  logic                  cmd_acc, wr_acc, rd_acc, wdf_push, bad_cmd;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH+STRB_WIDTH-1:0] wdf_head;
  word_t                 wdf_data;
  logic [STRB_WIDTH-1:0] wdf_mask;
  logic                  unused_addr_bits;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      calib_cnt <= '0;
      calib_q   <= 1'b0;
    end else if (!calib_q) begin
      calib_cnt <= calib_cnt + 1'b1;
      if (calib_cnt == CAL_W'(CALIB_CYCLES - 1)) calib_q <= 1'b1;
    end
  end

`ifdef MIG_RESP_BACKPRESSURE_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)      lfsr_q <= LFSR_SEED;
    else if (calib_q) lfsr_q <= lfsr_next(lfsr_q);
  end

  // Two disjoint bit pairs give independent 25% stall decisions.
  assign cmd_stall = (lfsr_q[1:0] == 2'b00);
  assign wdf_stall = (lfsr_q[3:2] == 2'b00);
`else
  assign cmd_stall = 1'b0;
  assign wdf_stall = 1'b0;
`endif

  assign wdf_rdy  = calib_q & ~wdf_full & ~wdf_stall;
  assign cmd_rdy  = calib_q & ~cmd_stall
                  & ~((app.app_cmd_i == MIG_CMD_WRITE) & wdf_empty);
  assign cmd_acc  = app.app_en_i & cmd_rdy;
  assign wr_acc   = cmd_acc & (app.app_cmd_i == MIG_CMD_WRITE);
  assign rd_acc   = cmd_acc & (app.app_cmd_i == MIG_CMD_READ);
  assign bad_cmd  = (app.app_cmd_i != MIG_CMD_WRITE) & (app.app_cmd_i != MIG_CMD_READ);
  assign wdf_push = app.app_wdf_wren_i & wdf_rdy;
  assign idx      = app.app_addr_i[IDX_W+2:3];
  assign unused_addr_bits = ^app.app_addr_i[ADDR_WIDTH-1:IDX_W+3];

  mig_wdf_fifo #(
    .WIDTH (DATA_WIDTH + STRB_WIDTH),
    .DEPTH (WDF_DEPTH)
  ) u_wdf (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (wdf_push),
    .wdata  ({app.app_wdf_mask_i, app.app_wdf_data_i}),
    .pop    (wr_acc),
    .rdata  (wdf_head),
    .full   (wdf_full),
    .empty  (wdf_empty)
  );

  assign wdf_data = wdf_head[DATA_WIDTH-1:0];
  assign wdf_mask = wdf_head[DATA_WIDTH+STRB_WIDTH-1:DATA_WIDTH];

  // NOTE: the memory array and data stages are deliberately left unreset; reset must not erase stored words.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (!wdf_mask[b]) mem[idx][b] <= wdf_data[b];
      end
    end
    rd_pipe[0] <= mem[idx];
    for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Valid bits travel beside the data; the output register adds the final cycle of latency.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_vld     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      rd_vld[0] <= rd_acc;
      for (int i = 1; i < RD_LATENCY; i++) rd_vld[i] <= rd_vld[i-1];
      rd_valid_q <= rd_vld[RD_LATENCY-1];
      rd_data_q  <= rd_vld[RD_LATENCY-1] ? rd_pipe[RD_LATENCY-1] : '0;
      if ((cmd_acc & ((app.app_addr_i[2:0] != 3'b000) | bad_cmd))
          | (app.app_wdf_wren_i != app.app_wdf_end_i)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign app.init_calib_complete_o = calib_q;
  assign app.app_rdy_o             = cmd_rdy;
  assign app.app_wdf_rdy_o         = wdf_rdy;
  assign app.app_rd_data_o         = rd_data_q;
  assign app.app_rd_data_valid_o   = rd_valid_q;
  assign app.app_rd_data_end_o     = rd_valid_q;
  assign app.err_o                 = err_q;
endmodule
